pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Instruction-fetch/next-PC stage. It consumes the branch-taken decision from the branch controller, plus jump/jr decode signals.
- It holds the PC and fetches from instruction memory over a req/ack handshake.
- It presents one instruction at a time to decode over a valid/ready handshake.
- It is the stage that acts on the branch compare result to redirect the PC.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset; low 2 bits must be 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address (word aligned).
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored unless imem_req=1.
- imem_rdata  in  32  fetched instruction word.
- inst_valid  out  1  instruction held for decode.
- inst_out  out  32  held instruction word.
- inst_pc  out  32  PC of the held instruction.
- inst_ready  in  1  decode/execute retires the held instruction this cycle.
- br_taken  in  1  branch condition true (branch controller output).
- br_offset  in  16  signed branch immediate (words).
- jump  in  1  j/jal of held instruction.
- jump_target  in  26  instr_index field.
- jr  in  1  jr/jalr of held instruction.
- jr_addr  in  32  register target.
- align_err  out  1  sticky: misaligned jr_addr seen.
- retired  out  32  count of retired instructions.

Behaviour:
- States: BOOT, FETCH, HOLD. Reset values:
  - state=BOOT, pc=RESET_PC
  - imem_req=0, inst_valid=0, inst_out=0, inst_pc=0
  - align_err=0, retired=0
- BOOT: imem_req=0 for exactly one cycle, so a memory aborts any request outstanding from before reset. Always goes to FETCH.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On imem_ack in the same cycle: latch inst_out=imem_rdata, inst_pc=pc, go to HOLD.
  - Zero-wait memory (ack in the first FETCH cycle) is legal.
- HOLD:
  - imem_req=0, inst_valid=1; inst_out and inst_pc stay stable until retire.
  - Retire = inst_valid & inst_ready. On retire: pc <= next_pc, retired <= retired+1 (wraps 0xFFFFFFFF->0), go to FETCH.
- Redirect inputs (br_taken, br_offset, jump, jump_target, jr, jr_addr) are sampled only in the retire cycle and are don't-care otherwise.
- next_pc, with p4 = inst_pc+4 (mod 2^32, so 0xFFFFFFFC -> 0). Priority jr > jump > br_taken > sequential:
  - jr: {jr_addr[31:2],2'b00}
  - jump: {p4[31:28], jump_target, 2'b00}
  - br_taken: p4 + (sign_extend(br_offset) << 2), mod 2^32
  - otherwise: p4
- Simultaneous jr and jump are a decode error; jr wins, no flag.
- If jr is selected and jr_addr[1:0]!=0, align_err is set at the same edge as the retire. It stays set until rst.
- Throughput: at most one instruction per 2 cycles (FETCH+HOLD). Retire at edge t gives imem_req=1 with the new address from t+1.
- imem_ack while imem_req=0 is ignored and changes no state.
- rst has priority over every event: mid-fetch, mid-hold, or coincident with ack/retire, all state returns to reset values and the ack or retire is dropped.

Test Plan:
- Reset then zero-wait memory, inst_ready=1, no redirects:
  - imem_addr sequence 0x3000, 0x3004, 0x3008.
  - inst_valid on alternate cycles; retired=3 after 3 retirements.
- Memory ack delayed 3 cycles:
  - imem_req high and imem_addr=0x3000 steady for 4 cycles.
  - inst_valid rises the cycle after ack; inst_pc=0x3000.
- Branches:
  - Held at 0x3010, retire with br_taken=1, br_offset=16'hFFFC: next imem_addr=0x3004.
  - Same with br_taken=0: next imem_addr=0x3014.
- Jump and jr:
  - jump=1, jump_target=26'h0000100 at inst_pc 0x3000: next imem_addr=0x0000_0400.
  - jr=1 and jump=1 together, jr_addr=0x0000_5006: next imem_addr=0x5004, align_err=1; align_err stays 1 until rst.
- Wrap and stall:
  - Held at 0xFFFFFFFC, sequential retire: next imem_addr=0x0000_0000.
  - inst_ready=0 for 5 cycles: inst_out and inst_pc unchanged, imem_req=0.
- Reset mid-operation:
  - rst during FETCH with ack the same cycle: ack discarded, inst_valid=0.
  - Next cycle is BOOT with imem_req=0, then imem_addr=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Instruction-fetch / next-PC stage. It owns the program counter, fetches one
// word at a time from instruction memory over a req/ack handshake and holds
// that word for decode over a valid/ready handshake. When decode retires the
// held instruction, the stage picks the next PC from the redirect inputs
// (jr > jump > taken branch > sequential) and starts the next fetch.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   imem_req/addr       fetch request and word-aligned fetch address
//   imem_ack/rdata      memory response; ack is ignored unless imem_req=1
//   inst_valid/out/pc   instruction currently held for decode, with its PC
//   inst_ready          decode retires the held instruction this cycle
//   br_taken/br_offset  branch decision and signed word offset
//   jump/jump_target    j/jal and its instr_index field
//   jr/jr_addr          jr/jalr and its register target
//   align_err           sticky flag: a misaligned jr target was retired
//   retired             running count of retired instructions
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic        align_err,
    output logic [31:0] retired
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // The low address bits are forced to zero so a careless parameter
    // override can never produce a misaligned fetch.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        align_err_q, align_err_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] p4;
    logic [31:0] br_disp;
    logic [31:0] next_pc;

    // Next-PC selection. All candidates are computed from the PC of the held
    // instruction, so the result is only meaningful in the retire cycle.
    always_comb begin
        p4      = inst_pc_q + 32'd4;
        br_disp = {{14{br_offset[15]}}, br_offset, 2'b00};
        if (jr) begin
            next_pc = {jr_addr[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {p4[31:28], jump_target, 2'b00};
        end else if (br_taken) begin
            next_pc = p4 + br_disp;
        end else begin
            next_pc = p4;
        end
    end

    // Stage sequencing. BOOT idles the request line for one cycle so a memory
    // can drop anything left over from before reset; an ack is only honoured
    // in FETCH, which keeps a stray ack from disturbing the held word.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_out_d  = inst_out_q;
        inst_pc_d   = inst_pc_q;
        align_err_d = align_err_q;
        retired_d   = retired_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    inst_out_d = imem_rdata;
                    inst_pc_d  = pc_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                    if (jr && (jr_addr[1:0] != 2'b00)) begin
                        align_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Reset dominates every other event, including a coincident ack or retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC_ALIGNED;
            inst_out_q  <= 32'd0;
            inst_pc_q   <= 32'd0;
            align_err_q <= 1'b0;
            retired_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_out_q  <= inst_out_d;
            inst_pc_q   <= inst_pc_d;
            align_err_q <= align_err_d;
            retired_q   <= retired_d;
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == HOLD);
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign align_err  = align_err_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed bench for pc_fetch_ctrl. A table of redirect vectors (starting PC,
// redirect inputs, expected next fetch address and align flag) is applied in
// a loop; hand-written sequences cover reset, zero-wait and delayed memory,
// decode stalls with stray acks, and reset colliding with ack or retire.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic        align_err;
    logic [31:0] retired;

    int checkCount;
    int failCount;
    int expRetired;

    typedef struct {
        logic [31:0] setPc;
        logic        brTaken;
        logic [15:0] brOffset;
        logic        jumpIn;
        logic [25:0] jumpTarget;
        logic        jrIn;
        logic [31:0] jrAddr;
        logic [31:0] expAddr;
        logic        expAlign;
    } vec_t;

    vec_t vecs [10];

    pc_fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .jump       (jump),
        .jump_target(jump_target),
        .jr         (jr),
        .jr_addr    (jr_addr),
        .align_err  (align_err),
        .retired    (retired)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it, so outputs are
    // sampled and inputs driven well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Complete a zero-wait fetch: ack in the first FETCH cycle.
    task automatic serveFetch(input logic [31:0] word);
        checkOutput("fetch_req", 32'(imem_req), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        checkOutput("hold_valid", 32'(inst_valid), 32'd1);
        checkOutput("hold_word", inst_out, word);
    endtask

    // Retire the held instruction with the given redirect inputs.
    task automatic applyStimulus(input logic bt, input logic [15:0] bo,
                                 input logic j, input logic [25:0] jt,
                                 input logic r, input logic [31:0] ra);
        inst_ready  = 1'b1;
        br_taken    = bt;
        br_offset   = bo;
        jump        = j;
        jump_target = jt;
        jr          = r;
        jr_addr     = ra;
        tick();
        inst_ready  = 1'b0;
        br_taken    = 1'b0;
        br_offset   = 16'h0;
        jump        = 1'b0;
        jump_target = 26'h0;
        jr          = 1'b0;
        jr_addr     = 32'h0;
        expRetired++;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expRetired = 0;
    endtask

    initial begin
        checkCount  = 0;
        failCount   = 0;
        expRetired  = 0;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        br_taken    = 1'b0;
        br_offset   = 16'h0;
        jump        = 1'b0;
        jump_target = 26'h0;
        jr          = 1'b0;
        jr_addr     = 32'h0;

        // setPc, brTaken, brOffset, jump, jumpTarget, jr, jrAddr, expAddr, expAlign
        vecs[0] = '{32'h0000_3010, 1'b1, 16'hFFFC, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_3004, 1'b0};
        vecs[1] = '{32'h0000_3010, 1'b0, 16'hFFFC, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_3014, 1'b0};
        vecs[2] = '{32'h0000_3000, 1'b0, 16'h0,    1'b1, 26'h0000100, 1'b0, 32'h0,         32'h0000_0400, 1'b0};
        vecs[3] = '{32'hFFFF_FFFC, 1'b0, 16'h0,    1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[4] = '{32'h0000_3000, 1'b1, 16'h0010, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_3044, 1'b0};
        vecs[5] = '{32'h7FFF_FFFC, 1'b1, 16'h0010, 1'b1, 26'h3FFFFFF, 1'b0, 32'h0,         32'h8FFF_FFFC, 1'b0};
        vecs[6] = '{32'hFFFF_FFFC, 1'b1, 16'h0001, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0004, 1'b0};
        vecs[7] = '{32'h0000_2000, 1'b1, 16'h0100, 1'b1, 26'h0000123, 1'b1, 32'h0000_4440, 32'h0000_4440, 1'b0};
        vecs[8] = '{32'h0000_3000, 1'b0, 16'h0,    1'b1, 26'h0000100, 1'b1, 32'h0000_5006, 32'h0000_5004, 1'b1};
        vecs[9] = '{32'h0000_3000, 1'b0, 16'h0,    1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_3004, 1'b1};

        // Reset state, then the single BOOT cycle and the first fetch.
        tick();
        tick();
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst_out", inst_out, 32'd0);
        checkOutput("rst_inst_pc", inst_pc, 32'd0);
        checkOutput("rst_align", 32'(align_err), 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        rst = 1'b0;
        checkOutput("boot_req", 32'(imem_req), 32'd0);
        tick();
        checkOutput("first_req", 32'(imem_req), 32'd1);
        checkOutput("first_addr", imem_addr, 32'h0000_3000);

        // Zero-wait memory, sequential stream, valid on alternate cycles.
        for (int i = 0; i < 3; i++) begin
            checkOutput("seq_addr", imem_addr, 32'h0000_3000 + 32'(4 * i));
            checkOutput("seq_valid_low", 32'(inst_valid), 32'd0);
            serveFetch(32'hA000_0000 + 32'(i));
            checkOutput("seq_inst_pc", inst_pc, 32'h0000_3000 + 32'(4 * i));
            applyStimulus(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        end
        checkOutput("seq_retired", retired, 32'd3);
        checkOutput("seq_next_addr", imem_addr, 32'h0000_300C);

        // Memory acks on the fourth request cycle.
        doReset();
        tick();
        for (int k = 0; k < 3; k++) begin
            checkOutput("wait_req", 32'(imem_req), 32'd1);
            checkOutput("wait_addr", imem_addr, 32'h0000_3000);
            checkOutput("wait_valid", 32'(inst_valid), 32'd0);
            tick();
        end
        checkOutput("wait_addr_last", imem_addr, 32'h0000_3000);
        serveFetch(32'h1234_5678);
        checkOutput("wait_inst_pc", inst_pc, 32'h0000_3000);

        // Decode stall of 5 cycles with a stray ack that must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("stall_req", 32'(imem_req), 32'd0);
            checkOutput("stall_word", inst_out, 32'h1234_5678);
            checkOutput("stall_pc", inst_pc, 32'h0000_3000);
        end
        imem_ack = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        checkOutput("stall_next_addr", imem_addr, 32'h0000_3004);

        // Redirect table: steer to setPc with an aligned jr, then retire the
        // instruction there with the vector's redirect inputs.
        for (int i = 0; i < 10; i++) begin
            serveFetch(32'h0BAD_0000 + 32'(i));
            applyStimulus(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, vecs[i].setPc);
            checkOutput($sformatf("vec%0d_setpc", i), imem_addr, vecs[i].setPc);
            serveFetch(32'h0000_1000 + 32'(i));
            checkOutput($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].setPc);
            applyStimulus(vecs[i].brTaken, vecs[i].brOffset, vecs[i].jumpIn,
                          vecs[i].jumpTarget, vecs[i].jrIn, vecs[i].jrAddr);
            checkOutput($sformatf("vec%0d_next_addr", i), imem_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_align", i), 32'(align_err), 32'(vecs[i].expAlign));
        end
        checkOutput("table_retired", retired, 32'(expRetired));

        // Reset coinciding with an ack in FETCH: the ack is dropped.
        checkOutput("rstf_pre_req", 32'(imem_req), 32'd1);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        tick();
        rst      = 1'b0;
        imem_ack = 1'b0;
        checkOutput("rstf_valid", 32'(inst_valid), 32'd0);
        checkOutput("rstf_boot_req", 32'(imem_req), 32'd0);
        checkOutput("rstf_inst_out", inst_out, 32'd0);
        checkOutput("rstf_align", 32'(align_err), 32'd0);
        checkOutput("rstf_retired", retired, 32'd0);
        tick();
        checkOutput("rstf_req", 32'(imem_req), 32'd1);
        checkOutput("rstf_addr", imem_addr, 32'h0000_3000);

        // Reset coinciding with a retire in HOLD: the retire is dropped.
        serveFetch(32'h5555_AAAA);
        rst        = 1'b1;
        inst_ready = 1'b1;
        jr         = 1'b1;
        jr_addr    = 32'h0000_7001;
        tick();
        rst        = 1'b0;
        inst_ready = 1'b0;
        jr         = 1'b0;
        jr_addr    = 32'h0;
        checkOutput("rsth_retired", retired, 32'd0);
        checkOutput("rsth_valid", 32'(inst_valid), 32'd0);
        checkOutput("rsth_align", 32'(align_err), 32'd0);
        tick();
        checkOutput("rsth_addr", imem_addr, 32'h0000_3000);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    // Safety net so the run always terminates on its own.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
